dbus_regfile: RTL and testbench

Register-bank responder on the internal dbus, the target end of the byte-wide register bus driven by the UART command FSM. Decodes `dbus_reg` and executes one write or one read per strobe assertion. Returns read data on `dbus_data_in`, exports control, pulse and configuration registers to the rest of the TDC, and collects sticky status flags.

---
 rtl/dbus_regfile.sv | 180 ++++++++++++++++++
 tb/tb_dbus_regfile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_regfile.sv
// dbus_regfile -- register-bank target on the internal byte-wide dbus.
//
// Decodes dbus_reg and performs one write or one read per strobe assertion.
// It returns registered read data and exports the CTRL, PULSE and general
// configuration registers. It also collects sticky status flags and counts
// accesses to unimplemented addresses.
//
// Parameters:
//   NREG      number of decoded addresses (8..64), 0x00..NREG-1
//   ID        constant returned at address 0x00
//   CTRL_RST  reset value of CTRL
//
// Ports:
//   sysclk         system clock, rising edge
//   reset          asynchronous active-low reset
//   dbus_reg       register address
//   dbus_data_out  write data from the bus initiator
//   dbus_w         write strobe (level, one write per rising edge)
//   dbus_r         read strobe (level, one read per rising edge)
//   dbus_data_in   registered read data back to the initiator
//   status_in      level status flags from the datapath
//   ctrl_out       CTRL register (0x01)
//   pulse_out      one-cycle pulses written at 0x02
//   cfg_out        general registers 0x06..NREG-1, 0x06 in the LSBs
//
// Build option:
//   DBUS_STATUS_SYNC_EN  when defined, status_in passes through a two-flop
//                        synchroniser before feeding STICKY and LIVE.

module dbus_regfile #(
  parameter int unsigned NREG     = 16,
  parameter logic [7:0]  ID       = 8'hA5,
  parameter logic [7:0]  CTRL_RST = 8'h00
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [7:0]            dbus_reg,
  input  logic [7:0]            dbus_data_out,
  input  logic                  dbus_w,
  input  logic                  dbus_r,
  output logic [7:0]            dbus_data_in,
  input  logic [7:0]            status_in,
  output logic [7:0]            ctrl_out,
  output logic [7:0]            pulse_out,
  output logic [8*(NREG-6)-1:0] cfg_out
);

  localparam int unsigned NCFG   = NREG - 6;
  localparam int unsigned IW     = (NCFG > 1) ? $clog2(NCFG) : 1;
  localparam logic [7:0]  NREG_B = 8'(NREG);

  typedef enum logic [7:0] {
    A_ID     = 8'h00,
    A_CTRL   = 8'h01,
    A_PULSE  = 8'h02,
    A_STICKY = 8'h03,
    A_LIVE   = 8'h04,
    A_ERRCNT = 8'h05,
    A_CFG0   = 8'h06
  } reg_addr_e;

  logic       w_q, r_q;
  logic       w_arm, r_arm;
  logic       rd_pend;
  logic [7:0] rd_addr;
  logic [7:0] sticky;
  logic [7:0] errcnt;
  logic [7:0] cfg [NCFG];
  logic [7:0] status_s;

  logic       wr, rd, wr_bad, rd_bad;
  logic [7:0] sel_addr, rd_val;
  logic [7:0] sticky_clr, sticky_nxt;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

`ifdef DBUS_STATUS_SYNC_EN
  logic [7:0] sync1, sync2;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= status_in;
      sync2 <= sync1;
    end
  end

  assign status_s = sync2;
`else
  assign status_s = status_in;
`endif

  // The arm flags block an access from a strobe that is already high when
  // reset releases. The strobe must be seen low once before it can access.
  assign wr     = dbus_w & ~w_q & w_arm;
  assign rd     = dbus_r & ~r_q & r_arm;
  assign wr_bad = wr & (dbus_reg >= NREG_B);
  assign rd_bad = rd & (dbus_reg >= NREG_B);

  always_comb begin
    err_inc = {1'b0, wr_bad} + {1'b0, rd_bad};
    err_sum = {1'b0, errcnt} + {7'b0, err_inc};
  end

  // Set wins over a coincident write-1-to-clear.
  always_comb begin
    sticky_clr = '0;
    if (wr && (dbus_reg == A_STICKY)) sticky_clr = dbus_data_out;
    sticky_nxt = (sticky & ~sticky_clr) | status_s;
  end

  // A deferred read uses the address captured on the strobe edge.
  // It sees register contents after the coincident write.
  always_comb begin
    sel_addr = rd_pend ? rd_addr : dbus_reg;
    rd_val   = '0;
    if (sel_addr < NREG_B) begin
      case (sel_addr)
        A_ID:     rd_val = ID;
        A_CTRL:   rd_val = ctrl_out;
        A_PULSE:  rd_val = '0;
        A_STICKY: rd_val = sticky;
        A_LIVE:   rd_val = status_s;
        A_ERRCNT: rd_val = errcnt;
        default:  rd_val = cfg[IW'(sel_addr - A_CFG0)];
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      w_q          <= 1'b0;
      r_q          <= 1'b0;
      w_arm        <= 1'b0;
      r_arm        <= 1'b0;
      rd_pend      <= 1'b0;
      rd_addr      <= '0;
      sticky       <= '0;
      errcnt       <= '0;
      dbus_data_in <= '0;
      ctrl_out     <= CTRL_RST;
      pulse_out    <= '0;
      for (int unsigned i = 0; i < NCFG; i++) cfg[i] <= '0;
    end else begin
      w_q       <= dbus_w;
      r_q       <= dbus_r;
      w_arm     <= w_arm | ~dbus_w;
      r_arm     <= r_arm | ~dbus_r;
      sticky    <= sticky_nxt;
      pulse_out <= '0;

      if (wr && (dbus_reg == A_ERRCNT)) errcnt <= '0;
      else if (err_sum[8])              errcnt <= '1;
      else                              errcnt <= err_sum[7:0];

      if (wr) begin
        case (dbus_reg)
          A_CTRL:  ctrl_out  <= dbus_data_out;
          A_PULSE: pulse_out <= dbus_data_out;
          default: begin
            if ((dbus_reg >= A_CFG0) && (dbus_reg < NREG_B))
              cfg[IW'(dbus_reg - A_CFG0)] <= dbus_data_out;
          end
        endcase
      end

      rd_pend <= rd & wr;
      if (rd & wr) rd_addr <= dbus_reg;
      if (rd_pend || (rd && !wr)) dbus_data_in <= rd_val;
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int unsigned i = 0; i < NCFG; i++) cfg_out[i*8 +: 8] = cfg[i];
  end

endmodule

// File: tb/tb_dbus_regfile.sv
// Testbench for dbus_regfile: directed steps followed by a randomized
// phase. The bus behaviour is modelled per access with plain arrays.
module tb_dbus_regfile;

  localparam int unsigned NREG     = 16;
  localparam logic [7:0]  ID       = 8'hA5;
  localparam logic [7:0]  CTRL_RST = 8'h00;

  logic                  sysclk = 1'b0;
  logic                  reset  = 1'b0;
  logic [7:0]            dbus_reg = '0;
  logic [7:0]            dbus_data_out = '0;
  logic                  dbus_w = 1'b0;
  logic                  dbus_r = 1'b0;
  logic [7:0]            dbus_data_in;
  logic [7:0]            status_in = '0;
  logic [7:0]            ctrl_out;
  logic [7:0]            pulse_out;
  logic [8*(NREG-6)-1:0] cfg_out;

  dbus_regfile #(.NREG(NREG), .ID(ID), .CTRL_RST(CTRL_RST)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .dbus_reg     (dbus_reg),
    .dbus_data_out(dbus_data_out),
    .dbus_w       (dbus_w),
    .dbus_r       (dbus_r),
    .dbus_data_in (dbus_data_in),
    .status_in    (status_in),
    .ctrl_out     (ctrl_out),
    .pulse_out    (pulse_out),
    .cfg_out      (cfg_out)
  );

  always #5 sysclk = ~sysclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the register bank
  logic [7:0] m_cfg [256];
  logic [7:0] m_ctrl, m_sticky, m_rdata;
  int         m_err;
  logic [7:0] clr_mask, snap_sticky, snap_live;
`ifdef DBUS_STATUS_SYNC_EN
  logic [7:0] st_d1, st_d2;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cfg();
    for (int i = 0; i < int'(NREG) - 6; i++)
      chk("cfg_out", cfg_out[i*8 +: 8], m_cfg[i+6]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_cfg[i] = 8'h00;
    m_ctrl = CTRL_RST; m_sticky = 8'h00; m_rdata = 8'h00; m_err = 0;
    clr_mask = 8'h00; snap_sticky = 8'h00; snap_live = 8'h00;
`ifdef DBUS_STATUS_SYNC_EN
    st_d1 = 8'h00; st_d2 = 8'h00;
`endif
  endtask

  // One clock edge. Sticky flags absorb the status seen at that edge.
  task automatic tick();
    logic [7:0] eff;
`ifdef DBUS_STATUS_SYNC_EN
    eff = st_d2; st_d2 = st_d1; st_d1 = status_in;
`else
    eff = status_in;
`endif
    snap_sticky = m_sticky;
    snap_live   = eff;
    m_sticky    = (m_sticky & ~clr_mask) | eff;
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (int'(a) >= int'(NREG)) return 8'h00;
    case (a)
      8'h00:   return ID;
      8'h01:   return m_ctrl;
      8'h02:   return 8'h00;
      8'h03:   return snap_sticky;
      8'h04:   return snap_live;
      8'h05:   return 8'(m_err);
      default: return m_cfg[a];
    endcase
  endfunction

  task automatic err_bump(input logic [7:0] a);
    if (int'(a) >= int'(NREG)) m_err = (m_err >= 255) ? 255 : m_err + 1;
  endtask

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (int'(a) >= int'(NREG)) err_bump(a);
    else if (a == 8'h01) m_ctrl = d;
    else if (a == 8'h05) m_err = 0;
    else if (a >= 8'h06) m_cfg[a] = d;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    dbus_reg = a; dbus_data_out = d; dbus_w = 1'b1;
    clr_mask = (a == 8'h03) ? d : 8'h00;
    tick();
    clr_mask = 8'h00;
    m_write(a, d);
    chk("wr_pulse", pulse_out, (a == 8'h02) ? d : 8'h00);
    chk("wr_ctrl", ctrl_out, m_ctrl);
    chk_cfg();
    dbus_w = 1'b0;
    tick();
    chk("pulse_end", pulse_out, 8'h00);
  endtask

  task automatic bus_read(input logic [7:0] a);
    dbus_reg = a; dbus_r = 1'b1;
    tick();
    m_rdata = m_read(a);
    chk("rd_data", dbus_data_in, m_rdata);
    err_bump(a);
    dbus_r = 1'b0;
    tick();
    chk("rd_hold", dbus_data_in, m_rdata);
  endtask

  initial begin
    model_reset();

    // Reset state
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_rdata", dbus_data_in, 8'h00);
    chk("rst_ctrl", ctrl_out, CTRL_RST);
    chk("rst_pulse", pulse_out, 8'h00);
    chk_cfg();
    @(negedge sysclk);
    reset = 1'b1;
    tick(); tick();

    // ID, CTRL, ERRCNT after reset
    bus_read(8'h00);
    chk("id", dbus_data_in, 8'hA5);
    bus_read(8'h01);
    bus_read(8'h05);

    // Held write strobe: one write only, later data is ignored
    dbus_reg = 8'h01; dbus_data_out = 8'h3C; dbus_w = 1'b1;
    tick();
    m_write(8'h01, 8'h3C);
    chk("ctrl_wr", ctrl_out, 8'h3C);
    dbus_data_out = 8'hC3;
    repeat (4) tick();
    chk("ctrl_held", ctrl_out, 8'h3C);
    dbus_w = 1'b0;
    tick();
    bus_read(8'h01);

    // Pulse register
    bus_write(8'h02, 8'h81);
    bus_read(8'h02);

    // Sticky: set wins over a coincident clear, then a plain clear
    status_in = 8'h10; tick();
    status_in = 8'h00; tick();
    status_in = 8'h10;
    bus_write(8'h03, 8'h10);
    status_in = 8'h00;
    repeat (3) tick();
    bus_read(8'h03);
    chk("sticky_kept", dbus_data_in, 8'h10);
    bus_write(8'h03, 8'h10);
    bus_read(8'h03);
    bus_read(8'h04);

    // Error counter saturation and clear
    for (int i = 0; i < 300; i++) bus_read(8'hF0);
    bus_read(8'h05);
    chk("err_sat", dbus_data_in, 8'hFF);
    bus_write(8'h05, 8'h77);
    bus_read(8'h05);

    // Coincident write and read: the read data arrives one edge later
    dbus_reg = 8'h06; dbus_data_out = 8'h5A; dbus_w = 1'b1; dbus_r = 1'b1;
    tick();
    m_write(8'h06, 8'h5A);
    dbus_w = 1'b0; dbus_r = 1'b0;
    chk("rw_cfg", cfg_out[7:0], 8'h5A);
    chk("rw_early", dbus_data_in, m_rdata);
    tick();
    m_rdata = m_read(8'h06);
    chk("rw_late", dbus_data_in, m_rdata);

    // Randomized phase
    for (int n = 0; n < 250; n++) begin
      logic [7:0] a, d;
      status_in = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) a = 8'h80 | 8'($urandom);
      else a = 8'($urandom_range(0, NREG + 1));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus_write(a, d);
      else bus_read(a);
    end
    status_in = 8'h00;
    repeat (3) tick();
    bus_read(8'h03);
    bus_read(8'h05);

    // Reset during a held write; the strobe must drop before any access
    dbus_reg = 8'h01; dbus_data_out = 8'h77; dbus_w = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_ctrl", ctrl_out, CTRL_RST);
    chk("midrst_rdata", dbus_data_in, 8'h00);
    @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (3) tick();
    chk("rel_held", ctrl_out, CTRL_RST);
    dbus_w = 1'b0;
    tick();
    chk("rel_noacc", ctrl_out, CTRL_RST);
    bus_write(8'h01, 8'h42);
    bus_read(8'h01);
    chk_cfg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
